keypad_scan_ctrl: RTL

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: rotates a one-hot column drive, debounces a single pressed
// row, and reports the accepted key until it has been released and debounced.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 4000,
    parameter int DEBOUNCE_CNT = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_CNT);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        row_meta_q, row_meta_d;
    logic [3:0]        row_s_q, row_s_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [3:0]        row_cap_q, row_cap_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_held_q, key_held_d;

    logic              row_onehot;
    logic              row_match;
    logic              row_zero;
    logic [1:0]        row_code;

    // Zero and multi-bit patterns both fail this test, so both read as "no key".
    assign row_onehot = (row_s_q != 4'd0) && ((row_s_q & (row_s_q - 4'd1)) == 4'd0);
    assign row_match  = (row_s_q == row_cap_q);
    assign row_zero   = (row_s_q == 4'd0);

    always_comb begin
        row_code = 2'd0;
        case (row_cap_q)
            4'b0001: row_code = 2'd0;
            4'b0010: row_code = 2'd1;
            4'b0100: row_code = 2'd2;
            4'b1000: row_code = 2'd3;
            default: row_code = 2'd0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            assign col[gi] = (col_idx_q == 2'(gi));
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        row_meta_d  = row;
        row_s_d     = row_meta_q;
        col_idx_d   = col_idx_q;
        scan_cnt_d  = scan_cnt_q;
        deb_cnt_d   = deb_cnt_q;
        row_cap_d   = row_cap_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        case (state_q)
            ST_SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (row_onehot) begin
                        row_cap_d = row_s_q;
                        deb_cnt_d = '0;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end

            ST_DEBOUNCE: begin
                if (row_match) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        state_d     = ST_HELD;
                        deb_cnt_d   = '0;
                        key_code_d  = {col_idx_q, row_code};
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end else begin
                    // Bounce, release or a second key: give up on this column.
                    state_d    = ST_SCAN;
                    col_idx_d  = col_idx_q + 2'd1;
                    scan_cnt_d = '0;
                    deb_cnt_d  = '0;
                end
            end

            ST_HELD: begin
                if (row_zero) begin
                    state_d   = ST_RELEASE;
                    deb_cnt_d = '0;
                end
            end

            ST_RELEASE: begin
                if (row_zero) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        state_d    = ST_SCAN;
                        key_held_d = 1'b0;
                        col_idx_d  = col_idx_q + 2'd1;
                        scan_cnt_d = '0;
                        deb_cnt_d  = '0;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end else begin
                    state_d   = ST_HELD;
                    deb_cnt_d = '0;
                end
            end

            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SCAN;
            row_meta_q  <= 4'd0;
            row_s_q     <= 4'd0;
            col_idx_q   <= 2'd0;
            scan_cnt_q  <= '0;
            deb_cnt_q   <= '0;
            row_cap_q   <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_meta_q  <= row_meta_d;
            row_s_q     <= row_s_d;
            col_idx_q   <= col_idx_d;
            scan_cnt_q  <= scan_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            row_cap_q   <= row_cap_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule
